load_store_unit: RTL and testbench

Sub-word load/store adapter between the CPU execute stage and the memory-map controller. Accepts byte, halfword and word loads and stores with RISC-V semantics, and issues only word-aligned 32-bit commands downstream. Loads are sign- or zero-extended. Byte and halfword stores become a read-modify-write sequence, so the memory and MMIO devices only ever see whole-word accesses. Misaligned requests are rejected with an error response and never reach memory.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used at request capture.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE,
        ST_RESP
    } lsu_state_t;

    // Size 3 has no legal encoding, so it is folded into the misaligned case.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_H) && addr_lo[0])
            || ((size == SIZE_W) && (addr_lo != 2'b00))
            || (size == 2'd3);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction with sign/zero extension for loads, and byte/half merge into
// a read word for sub-word stores. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [4:0]  shamt_b;
    logic [4:0]  shamt_h;
    logic [31:0] mask;
    logic [31:0] ins;

    assign shamt_b = {addr_lo, 3'b000};
    assign shamt_h = {addr_lo[1], 4'b0000};

    always_comb begin
        lane_b = word[7:0];
        case (addr_lo)
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            2'd3:    lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_value = word;
        case (size)
            SIZE_B:  load_value = zero_ext ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SIZE_H:  load_value = zero_ext ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_value = word;
        endcase
    end

    always_comb begin
        mask        = 32'h0;
        ins         = 32'h0;
        merged_word = store_data;
        case (size)
            SIZE_B: begin
                mask        = 32'h0000_00FF << shamt_b;
                ins         = {24'h0, store_data[7:0]} << shamt_b;
                merged_word = (word & ~mask) | ins;
            end
            SIZE_H: begin
                mask        = 32'h0000_FFFF << shamt_h;
                ins         = {16'h0, store_data[15:0]} << shamt_h;
                merged_word = (word & ~mask) | ins;
            end
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sub-word load/store adapter: turns byte/half/word CPU accesses into aligned
// 32-bit downstream commands, using read-modify-write for sub-word stores.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | ready for a CPU request; captures it on req_start
//   ST_RD_ISSUE | read command offered downstream until mem_cmd_ready
//   ST_RD_WAIT  | waiting for mem_rdata_valid (load data or RMW read word)
//   ST_WR_ISSUE | write command offered downstream until mem_cmd_ready
//   ST_RESP     | one-cycle rsp_valid pulse, then back to ST_IDLE
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_start,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_cmd_start,
    output logic        mem_cmd_write,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid
);

    lsu_state_t  state;
    logic [1:0]  hold_addr_lo;
    logic [1:0]  hold_size;
    logic        hold_write;
    logic        hold_unsigned;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    // Strobes decode the state register directly so reset removes them at once.
    assign req_ready     = (state == ST_IDLE);
    assign rsp_valid     = (state == ST_RESP);
    assign mem_cmd_start = (state == ST_RD_ISSUE) || (state == ST_WR_ISSUE);
    assign mem_cmd_write = (state == ST_WR_ISSUE);

    // mem_wdata still holds the right-justified store data while the RMW read
    // is outstanding, so it doubles as the merge source.
    lsu_lane_align u_lane_align (
        .word        (mem_rdata),
        .addr_lo     (hold_addr_lo),
        .size        (hold_size),
        .zero_ext    (hold_unsigned),
        .store_data  (mem_wdata),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            hold_addr_lo  <= 2'b00;
            hold_size     <= SIZE_B;
            hold_write    <= 1'b0;
            hold_unsigned <= 1'b0;
            rsp_rdata     <= 32'h0;
            rsp_error     <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_start) begin
                        hold_addr_lo  <= req_addr[1:0];
                        hold_size     <= req_size;
                        hold_write    <= req_write;
                        hold_unsigned <= req_unsigned;
                        mem_addr      <= {req_addr[31:2], 2'b00};
                        mem_wdata     <= req_wdata;
                        rsp_error     <= is_misaligned(req_size, req_addr[1:0]);
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            rsp_rdata <= 32'h0;
                            state     <= ST_RESP;
                        end else if (req_write && (req_size == SIZE_W)) begin
                            state <= ST_WR_ISSUE;
                        end else begin
                            state <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    if (mem_cmd_ready) state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (mem_rdata_valid) begin
                        if (hold_write) begin
                            mem_wdata <= merged_word;
                            state     <= ST_WR_ISSUE;
                        end else begin
                            rsp_rdata <= load_value;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_WR_ISSUE: begin
                    if (mem_cmd_ready) begin
                        rsp_rdata <= 32'h0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model
// that accepts commands and returns read data one cycle after acceptance.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_start;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_cmd_start;
    logic        mem_cmd_write;
    logic        mem_cmd_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rdata_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = 32'h0;
    logic [31:0] pl_data = 32'h0;
    logic        hold_rd = 1'b0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          start_cycles = 0;
    int          rsp_count = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk             (clk),
        .rst             (rst),
        .req_start       (req_start),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error),
        .mem_cmd_start   (mem_cmd_start),
        .mem_cmd_write   (mem_cmd_write),
        .mem_cmd_ready   (mem_cmd_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid)
    );

    always @(posedge clk) begin
        mem_rdata_valid <= 1'b0;
        if (pl_en) mem[pl_addr[11:2]] <= pl_data;
        if (mem_cmd_start && mem_cmd_ready) begin
            if (mem_cmd_write) begin
                mem[mem_addr[11:2]] <= mem_wdata;
                wr_count     <= wr_count + 1;
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_wdata;
            end else begin
                rd_count <= rd_count + 1;
                if (!hold_rd) begin
                    mem_rdata_valid <= 1'b1;
                    mem_rdata       <= mem[mem_addr[11:2]];
                end
            end
        end
        if (mem_cmd_start) start_cycles <= start_cycles + 1;
        if (rsp_valid) rsp_count <= rsp_count + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    // lat counts rising edges from the accepting edge through the one entering RESP.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_start    = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 req_start = 1'b0;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("rsp_valid", {31'h0, rsp_valid}, 32'h1);
        rd = rsp_rdata;
        er = rsp_error;
        @(negedge clk);
        check_eq("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] exp;
    } load_vec_t;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
    } mis_vec_t;

    load_vec_t loads [9] = '{
        '{2'd0, 1'b0, 32'h102, 32'hFFFF_FFFF},
        '{2'd0, 1'b1, 32'h103, 32'h0000_0080},
        '{2'd0, 1'b0, 32'h100, 32'h0000_0001},
        '{2'd0, 1'b0, 32'h103, 32'hFFFF_FF80},
        '{2'd1, 1'b0, 32'h100, 32'h0000_7F01},
        '{2'd1, 1'b1, 32'h102, 32'h0000_80FF},
        '{2'd1, 1'b0, 32'h102, 32'hFFFF_80FF},
        '{2'd2, 1'b0, 32'h100, 32'h80FF_7F01},
        '{2'd2, 1'b1, 32'h100, 32'h80FF_7F01}
    };

    mis_vec_t mis [5] = '{
        '{1'b0, 2'd2, 32'h101},
        '{1'b0, 2'd1, 32'h101},
        '{1'b0, 2'd3, 32'h100},
        '{1'b1, 2'd2, 32'h302},
        '{1'b1, 2'd1, 32'h203}
    };

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          r0, w0, s0, c0;

        rst           = 1'b1;
        req_start     = 1'b0;
        req_write     = 1'b0;
        req_size      = 2'd0;
        req_unsigned  = 1'b0;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        mem_cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
        check_eq("rst_cmd_start", {31'h0, mem_cmd_start}, 32'h0);
        check_eq("rst_cmd_write", {31'h0, mem_cmd_write}, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);

        preload(32'h100, 32'h80FF_7F01);
        preload(32'h104, 32'h1122_3344);
        preload(32'h200, 32'hAABB_CCDD);
        preload(32'h204, 32'hCAFE_F00D);

        foreach (loads[i]) begin
            do_req(1'b0, loads[i].sz, loads[i].uns, loads[i].addr, 32'h0, rd, er, lat);
            check_eq($sformatf("load_data_%0d", i), rd, loads[i].exp);
            check_eq($sformatf("load_err_%0d", i), {31'h0, er}, 32'h0);
            check_eq($sformatf("load_lat_%0d", i), lat, 32'd3);
        end

        // rsp_rdata is non-zero here, so a zero on the error response is meaningful.
        foreach (mis[i]) begin
            s0 = start_cycles;
            do_req(mis[i].wr, mis[i].sz, 1'b0, mis[i].addr, 32'h5555_5555, rd, er, lat);
            check_eq($sformatf("mis_err_%0d", i), {31'h0, er}, 32'h1);
            check_eq($sformatf("mis_lat_%0d", i), lat, 32'd1);
            check_eq($sformatf("mis_rdata_%0d", i), rd, 32'h0);
            check_eq($sformatf("mis_no_cmd_%0d", i), start_cycles - s0, 32'd0);
        end

        r0 = rd_count;
        w0 = wr_count;
        do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_1234, rd, er, lat);
        check_eq("sh_err", {31'h0, er}, 32'h0);
        check_eq("sh_rdata", rd, 32'h0);
        check_eq("sh_lat", lat, 32'd4);
        check_eq("sh_reads", rd_count - r0, 32'd1);
        check_eq("sh_writes", wr_count - w0, 32'd1);
        check_eq("sh_wr_addr", last_wr_addr, 32'h200);
        check_eq("sh_wr_data", last_wr_data, 32'h1234_CCDD);

        // Backpressure on the RMW read of an SB to 0x105.
        req_write     = 1'b1;
        req_size      = 2'd0;
        req_unsigned  = 1'b0;
        req_addr      = 32'h105;
        req_wdata     = 32'h0000_00AB;
        mem_cmd_ready = 1'b0;
        req_start     = 1'b1;
        @(posedge clk);
        #1 req_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("bp_start_%0d", i), {31'h0, mem_cmd_start}, 32'h1);
            check_eq($sformatf("bp_addr_%0d", i), mem_addr, 32'h104);
        end
        mem_cmd_ready = 1'b1;
        @(posedge clk);
        #1 check_eq("bp_accept", {31'h0, mem_cmd_start}, 32'h0);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check_eq("bp_rsp_error", {31'h0, rsp_error}, 32'h0);
        @(negedge clk);
        check_eq("bp_mem_word", mem[32'h104 >> 2], 32'h1122_AB44);
        do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, rd, er, lat);
        check_eq("bp_readback", rd, 32'h1122_AB44);

        // Reset while an SB sits in RD_WAIT.
        hold_rd      = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'd0;
        req_addr     = 32'h206;
        req_wdata    = 32'h0000_0055;
        req_start    = 1'b1;
        @(posedge clk);
        #1 req_start = 1'b0;
        @(posedge clk);
        #1 check_eq("rw_wait_start", {31'h0, mem_cmd_start}, 32'h0);
        w0 = wr_count;
        c0 = rsp_count;
        #2 rst = 1'b1;
        #1 check_eq("rw_rst_start", {31'h0, mem_cmd_start}, 32'h0);
        check_eq("rw_rst_ready", {31'h0, req_ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        hold_rd = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rw_no_write", wr_count - w0, 32'd0);
        check_eq("rw_no_rsp", rsp_count - c0, 32'd0);
        check_eq("rw_ready_after", {31'h0, req_ready}, 32'h1);
        do_req(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, rd, er, lat);
        check_eq("rw_mem_intact", rd, 32'hCAFE_F00D);

        // Reset while a read command is being offered drops the strobe at once.
        mem_cmd_ready = 1'b0;
        req_write     = 1'b0;
        req_size      = 2'd2;
        req_addr      = 32'h100;
        req_start     = 1'b1;
        @(posedge clk);
        #1 req_start = 1'b0;
        check_eq("ri_start", {31'h0, mem_cmd_start}, 32'h1);
        #2 rst = 1'b1;
        #1 check_eq("ri_rst_start", {31'h0, mem_cmd_start}, 32'h0);
        @(negedge clk);
        rst           = 1'b0;
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        check_eq("ri_ready_after", {31'h0, req_ready}, 32'h1);

        do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEAD_BEEF, rd, er, lat);
        check_eq("sw_lat", lat, 32'd2);
        check_eq("sw_err", {31'h0, er}, 32'h0);
        check_eq("sw_rdata", rd, 32'h0);
        check_eq("sw_wr_data", last_wr_data, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd1, 1'b0, 32'h302, 32'h0, rd, er, lat);
        check_eq("lh_after_sw", rd, 32'hFFFF_DEAD);
        do_req(1'b0, 2'd0, 1'b1, 32'h301, 32'h0, rd, er, lat);
        check_eq("lbu_after_sw", rd, 32'h0000_00BE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
